// File: rtl/aes_dec_sequencer.sv
`default_nettype none
// ============================================================================
// aes_dec_sequencer : round/key sequencer for an iterative AES inverse cipher
// Revision: 1.0
// ============================================================================
module aes_dec_sequencer #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_in,
  output logic [127:0] round_state,
  output logic [1:0]   round_sel,
  output logic [3:0]   key_idx,
  input  logic         key_valid,
  input  logic [127:0] round_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_out,
  output logic         busy
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [1:0] c_sel_first  = 2'd0;
  localparam logic [1:0] c_sel_middle = 2'd1;
  localparam logic [1:0] c_sel_final  = 2'd2;

  localparam logic [3:0] c_nr = 4'(NR);

  logic [1:0]   r_fsm;
  logic [3:0]   r_cnt;
  logic [127:0] r_state;
  logic         r_armed;
  logic         w_accept;

  // in_ready stays low until the first clock edge after reset release
  assign in_ready = r_armed & ((r_fsm == c_idle) | ((r_fsm == c_done) & out_ready));
  assign w_accept = in_valid & in_ready;

  assign round_state = r_state;
  assign plain_out   = r_state;
  assign busy        = (r_fsm == c_run);
  assign out_valid   = (r_fsm == c_done);
  assign key_idx     = (r_fsm == c_run) ? r_cnt : 4'd0;

  always_comb begin
    round_sel = c_sel_first;
    if (r_fsm == c_run) begin
      if (r_cnt == c_nr)
        round_sel = c_sel_first;
      else if (r_cnt == 4'd0)
        round_sel = c_sel_final;
      else
        round_sel = c_sel_middle;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm   <= c_idle;
      r_cnt   <= 4'd0;
      r_state <= 128'd0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      case (r_fsm)
        c_idle: begin
          if (w_accept) begin
            r_state <= cipher_in;
            r_cnt   <= c_nr;
            r_fsm   <= c_run;
          end
        end
        c_run: begin
          // key_valid low is a stall: state, counter and FSM all hold
          if (key_valid) begin
            r_state <= round_result;
            if (r_cnt == 4'd0)
              r_fsm <= c_done;
            else
              r_cnt <= r_cnt - 4'd1;
          end
        end
        c_done: begin
          if (out_ready) begin
            if (w_accept) begin
              r_state <= cipher_in;
              r_cnt   <= c_nr;
              r_fsm   <= c_run;
            end else begin
              r_fsm <= c_idle;
            end
          end
        end
        default: r_fsm <= c_idle;
      endcase
    end
  end

endmodule
`default_nettype wire
